// File: rtl/multicycle_ctrl_fsm.sv
// rtl/multicycle_ctrl_fsm.sv - multicycle RV32I sequencer driving a shared ALU and memory port
module multicycle_ctrl_fsm #(
    parameter int OP_CODE_WIDTH = 7,
    parameter int FUNCT3_WIDTH  = 3,
    parameter int FUNCT7_WIDTH  = 7,
    parameter int MEM_TIMEOUT   = 16
) (
    input  logic                     i_clk,
    input  logic                     i_reset_n,
    input  logic [OP_CODE_WIDTH-1:0] i_op_code,
    input  logic [FUNCT3_WIDTH-1:0]  i_funct3,
    input  logic [FUNCT7_WIDTH-1:0]  i_funct7,
    input  logic                     i_alu_zero_flag,
    input  logic                     i_mem_ready,
    output logic                     o_mem_req,
    output logic                     o_mem_we,
    output logic                     o_adr_src,
    output logic                     o_ir_wr,
    output logic                     o_pc_wr,
    output logic [1:0]               o_alu_src_a,
    output logic [1:0]               o_alu_src_b,
    output logic [3:0]               o_alu_op,
    output logic [1:0]               o_imm_sel,
    output logic [1:0]               o_result_sel,
    output logic                     o_reg_file_wr_en,
    output logic                     o_illegal_instr,
    output logic                     o_bus_error,
    output logic [3:0]               o_state
);

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_MEM_ADR  = 4'd3,
        S_MEM_RD   = 4'd4,
        S_MEM_WB   = 4'd5,
        S_MEM_WR   = 4'd6,
        S_EXEC_R   = 4'd7,
        S_EXEC_I   = 4'd8,
        S_ALU_WB   = 4'd9,
        S_BRANCH   = 4'd10,
        S_JAL      = 4'd11,
        S_JALR_ADR = 4'd12,
        S_JALR     = 4'd13,
        S_ILLEGAL  = 4'd14
    } state_t;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_R      = 7'b0110011;
    localparam logic [6:0] OPC_I      = 7'b0010011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_SLL  = 4'b0010;
    localparam logic [3:0] ALU_SLT  = 4'b0011;
    localparam logic [3:0] ALU_SLTU = 4'b0100;
    localparam logic [3:0] ALU_XOR  = 4'b0101;
    localparam logic [3:0] ALU_SRL  = 4'b0110;
    localparam logic [3:0] ALU_SRA  = 4'b0111;
    localparam logic [3:0] ALU_OR   = 4'b1000;
    localparam logic [3:0] ALU_AND  = 4'b1001;

    localparam int              CW        = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);
    localparam logic [CW-1:0]   TMO_LIMIT = CW'(MEM_TIMEOUT);

    state_t        state;
    logic [CW-1:0] wait_cnt;
    logic [6:0]    opc;
    logic [2:0]    f3;
    logic          f7_b5;
    logic          waiting;
    logic          timed_out;
    logic          mem_done;
    logic [3:0]    alu_fn;
    logic          unused_funct7;

    assign opc           = i_op_code[6:0];
    assign f3            = i_funct3[2:0];
    assign f7_b5         = i_funct7[5];
    assign unused_funct7 = ^{i_funct7[FUNCT7_WIDTH-1:6], i_funct7[4:0]};

    assign waiting   = (state == S_FETCH) || (state == S_MEM_RD) || (state == S_MEM_WR);
    assign timed_out = (MEM_TIMEOUT != 0) && waiting && (wait_cnt == TMO_LIMIT);
    assign mem_done  = waiting && i_mem_ready && !timed_out;

    // Counter is zero in every non-waiting state, so entering a waiting state always starts from 0.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state    <= S_IDLE;
            wait_cnt <= '0;
        end else begin
            if ((MEM_TIMEOUT != 0) && waiting && !i_mem_ready && !timed_out)
                wait_cnt <= wait_cnt + CW'(1);
            else
                wait_cnt <= '0;

            case (state)
                S_IDLE:   state <= S_FETCH;
                S_FETCH:  if (mem_done) state <= S_DECODE;
                S_DECODE: begin
                    case (opc)
                        OPC_LOAD, OPC_STORE: state <= S_MEM_ADR;
                        OPC_R:               state <= S_EXEC_R;
                        OPC_I:               state <= S_EXEC_I;
                        OPC_BRANCH:          state <= S_BRANCH;
                        OPC_JAL:             state <= S_JAL;
                        OPC_JALR:            state <= S_JALR_ADR;
                        default:             state <= S_ILLEGAL;
                    endcase
                end
                S_MEM_ADR: begin
                    if (f3 != 3'b010)          state <= S_ILLEGAL;
                    else if (opc == OPC_STORE) state <= S_MEM_WR;
                    else                       state <= S_MEM_RD;
                end
                S_MEM_RD: begin
                    if (timed_out)     state <= S_FETCH;
                    else if (mem_done) state <= S_MEM_WB;
                end
                S_MEM_WB:   state <= S_FETCH;
                S_MEM_WR:   if (timed_out || mem_done) state <= S_FETCH;
                S_EXEC_R:   state <= S_ALU_WB;
                S_EXEC_I:   state <= S_ALU_WB;
                S_ALU_WB:   state <= S_FETCH;
                S_BRANCH:   state <= (f3[2:1] == 2'b00) ? S_FETCH : S_ILLEGAL;
                S_JAL:      state <= S_ALU_WB;
                S_JALR_ADR: state <= S_JALR;
                S_JALR:     state <= S_ALU_WB;
                S_ILLEGAL:  state <= S_FETCH;
                default:    state <= S_IDLE;
            endcase
        end
    end

    // funct7[5] selects sub only for register ops; for immediates it is an immediate bit except on shifts.
    always_comb begin
        alu_fn = ALU_ADD;
        case (f3)
            3'b000:  alu_fn = (f7_b5 && (state == S_EXEC_R)) ? ALU_SUB : ALU_ADD;
            3'b001:  alu_fn = ALU_SLL;
            3'b010:  alu_fn = ALU_SLT;
            3'b011:  alu_fn = ALU_SLTU;
            3'b100:  alu_fn = ALU_XOR;
            3'b101:  alu_fn = f7_b5 ? ALU_SRA : ALU_SRL;
            3'b110:  alu_fn = ALU_OR;
            default: alu_fn = ALU_AND;
        endcase
    end

    always_comb begin
        o_mem_req        = 1'b0;
        o_mem_we         = 1'b0;
        o_adr_src        = 1'b0;
        o_ir_wr          = 1'b0;
        o_pc_wr          = 1'b0;
        o_alu_src_a      = 2'b00;
        o_alu_src_b      = 2'b00;
        o_alu_op         = ALU_ADD;
        o_imm_sel        = 2'b00;
        o_result_sel     = 2'b00;
        o_reg_file_wr_en = 1'b0;
        o_illegal_instr  = 1'b0;
        o_bus_error      = 1'b0;
        o_state          = state;

        if (state != S_IDLE) begin
            case (opc)
                OPC_STORE:  o_imm_sel = 2'b01;
                OPC_BRANCH: o_imm_sel = 2'b10;
                OPC_JAL:    o_imm_sel = 2'b11;
                default:    o_imm_sel = 2'b00;
            endcase
        end

        case (state)
            S_FETCH: begin
                o_mem_req    = !timed_out;
                o_alu_src_b  = 2'b10;
                o_result_sel = 2'b10;
                o_ir_wr      = mem_done;
                o_pc_wr      = mem_done;
                o_bus_error  = timed_out;
            end
            S_DECODE: begin
                o_alu_src_a = 2'b01;
                o_alu_src_b = 2'b01;
            end
            S_MEM_ADR, S_JALR_ADR: begin
                o_alu_src_a = 2'b10;
                o_alu_src_b = 2'b01;
            end
            S_MEM_RD: begin
                o_mem_req   = !timed_out;
                o_adr_src   = 1'b1;
                o_bus_error = timed_out;
            end
            S_MEM_WB: begin
                o_result_sel     = 2'b01;
                o_reg_file_wr_en = 1'b1;
            end
            S_MEM_WR: begin
                o_mem_req   = !timed_out;
                o_mem_we    = !timed_out;
                o_adr_src   = 1'b1;
                o_bus_error = timed_out;
            end
            S_EXEC_R: begin
                o_alu_src_a = 2'b10;
                o_alu_op    = alu_fn;
            end
            S_EXEC_I: begin
                o_alu_src_a = 2'b10;
                o_alu_src_b = 2'b01;
                o_alu_op    = alu_fn;
            end
            S_ALU_WB: o_reg_file_wr_en = 1'b1;
            S_BRANCH: begin
                o_alu_src_a = 2'b10;
                o_alu_op    = ALU_SUB;
                o_pc_wr     = ((f3 == 3'b000) && i_alu_zero_flag) ||
                              ((f3 == 3'b001) && !i_alu_zero_flag);
            end
            S_JAL, S_JALR: begin
                o_alu_src_a = 2'b01;
                o_alu_src_b = 2'b10;
                o_pc_wr     = 1'b1;
            end
            S_ILLEGAL: o_illegal_instr = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// tb/tb_multicycle_ctrl_fsm.sv - directed bench for multicycle_ctrl_fsm with per-cycle expectation plans
module tb_multicycle_ctrl_fsm;

    localparam int TMO = 4;

    typedef struct packed {
        logic [3:0] st;
        logic       req, we, adr, irw, pcw;
        logic [1:0] sa, sb;
        logic [3:0] aop;
        logic [1:0] imm, rs;
        logic       wen, ill, berr;
    } outs_t;

    typedef struct {
        logic [31:0] ins;
        logic        rdy;
        logic        zero;
        outs_t       e;
    } cyc_t;

    logic       clk;
    logic       rst_n;
    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    logic       zero;
    logic       rdy;
    logic       o_mem_req, o_mem_we, o_adr_src, o_ir_wr, o_pc_wr;
    logic [1:0] o_alu_src_a, o_alu_src_b, o_imm_sel, o_result_sel;
    logic [3:0] o_alu_op, o_state;
    logic       o_reg_file_wr_en, o_illegal_instr, o_bus_error;
    outs_t      act;

    int checks   = 0;
    int failures = 0;

    cyc_t        pq[$];
    cyc_t        cq[$];
    logic [31:0] cur_ins;
    logic        cur_zero;

    multicycle_ctrl_fsm #(
        .OP_CODE_WIDTH(7), .FUNCT3_WIDTH(3), .FUNCT7_WIDTH(7), .MEM_TIMEOUT(TMO)
    ) dut (
        .i_clk(clk), .i_reset_n(rst_n),
        .i_op_code(op), .i_funct3(f3), .i_funct7(f7),
        .i_alu_zero_flag(zero), .i_mem_ready(rdy),
        .o_mem_req(o_mem_req), .o_mem_we(o_mem_we), .o_adr_src(o_adr_src),
        .o_ir_wr(o_ir_wr), .o_pc_wr(o_pc_wr),
        .o_alu_src_a(o_alu_src_a), .o_alu_src_b(o_alu_src_b), .o_alu_op(o_alu_op),
        .o_imm_sel(o_imm_sel), .o_result_sel(o_result_sel),
        .o_reg_file_wr_en(o_reg_file_wr_en), .o_illegal_instr(o_illegal_instr),
        .o_bus_error(o_bus_error), .o_state(o_state)
    );

    assign act = {o_state, o_mem_req, o_mem_we, o_adr_src, o_ir_wr, o_pc_wr,
                  o_alu_src_a, o_alu_src_b, o_alu_op, o_imm_sel, o_result_sel,
                  o_reg_file_wr_en, o_illegal_instr, o_bus_error};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (cq.size() > 0) begin
            cyc_t c;
            c = cq.pop_front();
            checks++;
            if (act !== c.e) begin
                failures++;
                $display("FAIL cycle ins=%h got=%h exp=%h", c.ins, act, c.e);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    function automatic logic [31:0] mk(input logic [6:0] o, input logic [2:0] fn3, input logic [6:0] fn7);
        return {fn7, 10'd0, fn3, 5'd0, o};
    endfunction

    function automatic logic [1:0] imm_exp(input logic [6:0] o);
        if (o == 7'h23) return 2'd1;
        if (o == 7'h63) return 2'd2;
        if (o == 7'h6F) return 2'd3;
        return 2'd0;
    endfunction

    function automatic logic [3:0] alu_exp(input logic [2:0] fn3, input logic f75, input bit is_r);
        logic [3:0] tab [8];
        logic [3:0] r;
        tab = '{4'd0, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd8, 4'd9};
        r = tab[fn3];
        if (fn3 == 3'd0 && f75 && is_r) r = 4'd1;
        if (fn3 == 3'd5 && f75)         r = 4'd7;
        return r;
    endfunction

    function automatic cyc_t base(input logic [3:0] st);
        cyc_t c;
        c.ins   = cur_ins;
        c.zero  = cur_zero;
        c.rdy   = 1'b0;
        c.e     = '0;
        c.e.st  = st;
        c.e.imm = imm_exp(cur_ins[6:0]);
        return c;
    endfunction

    task automatic fetch_cyc(input bit ready, input bit err);
        cyc_t c;
        c = base(4'd1);
        c.rdy = ready;
        c.e.sb = 2'd2;
        c.e.rs = 2'd2;
        c.e.req = !err;
        c.e.berr = err;
        c.e.irw = ready && !err;
        c.e.pcw = ready && !err;
        pq.push_back(c);
    endtask

    task automatic mem_phase(input logic [3:0] st, input logic w, input int mw, output bit ok);
        cyc_t c;
        for (int i = 0; i < mw && i < TMO; i++) begin
            c = base(st); c.e.req = 1; c.e.we = w; c.e.adr = 1; pq.push_back(c);
        end
        c = base(st);
        c.e.adr = 1;
        if (mw >= TMO) begin
            c.e.berr = 1; ok = 0;
        end else begin
            c.rdy = 1; c.e.req = 1; c.e.we = w; ok = 1;
        end
        pq.push_back(c);
    endtask

    task automatic alu_wb();
        cyc_t c;
        c = base(4'd9); c.e.wen = 1; pq.push_back(c);
    endtask

    task automatic illegal_cyc();
        cyc_t c;
        c = base(4'd14); c.e.ill = 1; pq.push_back(c);
    endtask

    // Expected cycle-by-cycle outputs for one instruction; fw/mw = cycles memory withholds ready.
    task automatic plan(input logic [31:0] ins, input bit z, input int fw, input int mw);
        cyc_t c;
        bit ok;
        logic [6:0] o;
        logic [2:0] fn3;
        logic f75;
        o = ins[6:0]; fn3 = ins[14:12]; f75 = ins[30];
        cur_ins = ins; cur_zero = z;
        for (int i = 0; i < fw && i < TMO; i++) fetch_cyc(0, 0);
        if (fw >= TMO) fetch_cyc(0, 1);
        fetch_cyc(1, 0);
        c = base(4'd2); c.e.sa = 1; c.e.sb = 1; pq.push_back(c);
        if (o == 7'h03 || o == 7'h23) begin
            c = base(4'd3); c.e.sa = 2; c.e.sb = 1; pq.push_back(c);
            if (fn3 != 3'b010) illegal_cyc();
            else if (o == 7'h03) begin
                mem_phase(4'd4, 0, mw, ok);
                if (ok) begin
                    c = base(4'd5); c.e.rs = 1; c.e.wen = 1; pq.push_back(c);
                end
            end else mem_phase(4'd6, 1, mw, ok);
        end else if (o == 7'h33 || o == 7'h13) begin
            c = base((o == 7'h33) ? 4'd7 : 4'd8);
            c.e.sa = 2; c.e.sb = (o == 7'h33) ? 2'd0 : 2'd1;
            c.e.aop = alu_exp(fn3, f75, o == 7'h33);
            pq.push_back(c);
            alu_wb();
        end else if (o == 7'h63) begin
            c = base(4'd10); c.e.sa = 2; c.e.aop = 4'd1;
            c.e.pcw = (fn3 == 3'd0) ? z : ((fn3 == 3'd1) ? !z : 1'b0);
            pq.push_back(c);
            if (fn3 > 3'd1) illegal_cyc();
        end else if (o == 7'h6F) begin
            c = base(4'd11); c.e.sa = 1; c.e.sb = 2; c.e.pcw = 1; pq.push_back(c);
            alu_wb();
        end else if (o == 7'h67) begin
            c = base(4'd12); c.e.sa = 2; c.e.sb = 1; pq.push_back(c);
            c = base(4'd13); c.e.sa = 1; c.e.sb = 2; c.e.pcw = 1; pq.push_back(c);
            alu_wb();
        end else illegal_cyc();
    endtask

    task automatic drive(input int n);
        int k;
        cyc_t c;
        k = 0;
        while (pq.size() > 0 && (n < 0 || k < n)) begin
            c = pq.pop_front();
            @(posedge clk); #1;
            op = c.ins[6:0]; f3 = c.ins[14:12]; f7 = c.ins[31:25];
            rdy = c.rdy; zero = c.zero;
            cq.push_back(c);
            k++;
        end
        pq.delete();
        @(negedge clk); #1;
    endtask

    task automatic release_reset();
        cyc_t c;
        @(posedge clk); #1;
        rst_n = 1'b1;
        c.ins = '0; c.rdy = 1'b1; c.zero = 1'b0; c.e = '0;
        op = '0; f3 = '0; f7 = '0; rdy = 1'b1; zero = 1'b0;
        cq.push_back(c);
    endtask

    initial begin
        rst_n = 1'b0; op = '0; f3 = '0; f7 = '0; zero = 1'b0; rdy = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        chk("rst_state", {28'd0, o_state}, 32'd0);
        chk("rst_outs", {8'd0, act}, 32'd0);
        release_reset();

        plan(32'h002081B3, 0, 0, 0);
        chk("len_add", pq.size(), 4);
        chk("add_op", {28'd0, pq[2].e.aop}, 32'd0);
        drive(-1);
        plan(32'h402081B3, 0, 0, 0);
        chk("sub_op", {28'd0, pq[2].e.aop}, 32'd1);
        drive(-1);
        for (int i = 1; i < 8; i++) begin
            plan(mk(7'h33, 3'(i), 7'h00), 0, 0, 0); drive(-1);
        end
        plan(mk(7'h33, 3'd5, 7'h20), 0, 0, 0);
        chk("sra_op", {28'd0, pq[2].e.aop}, 32'd7);
        drive(-1);
        plan(mk(7'h13, 3'd0, 7'h20), 0, 0, 0);
        chk("addi_f7_op", {28'd0, pq[2].e.aop}, 32'd0);
        drive(-1);
        plan(mk(7'h13, 3'd5, 7'h20), 0, 1, 0); drive(-1);
        plan(mk(7'h13, 3'd6, 7'h00), 0, 0, 0); drive(-1);

        plan(mk(7'h03, 3'd2, 7'h00), 0, 0, 3);
        chk("len_lw_late", pq.size(), 8);
        drive(-1);
        plan(mk(7'h03, 3'd2, 7'h00), 0, 0, 0);
        chk("len_lw", pq.size(), 5);
        drive(-1);
        plan(mk(7'h03, 3'd0, 7'h00), 0, 0, 0); drive(-1);
        plan(mk(7'h23, 3'd2, 7'h00), 0, 0, 0);
        chk("len_sw", pq.size(), 4);
        drive(-1);
        plan(mk(7'h23, 3'd2, 7'h00), 0, 2, 2); drive(-1);

        plan(mk(7'h63, 3'd0, 7'h00), 1, 0, 0);
        chk("len_beq", pq.size(), 3);
        chk("beq_taken", {31'd0, pq[2].e.pcw}, 32'd1);
        drive(-1);
        plan(mk(7'h63, 3'd0, 7'h00), 0, 0, 0); drive(-1);
        plan(mk(7'h63, 3'd1, 7'h00), 1, 0, 0); drive(-1);
        plan(mk(7'h63, 3'd1, 7'h00), 0, 0, 0); drive(-1);
        plan(mk(7'h63, 3'd4, 7'h00), 1, 0, 0); drive(-1);

        plan(mk(7'h6F, 3'd0, 7'h00), 0, 0, 0); drive(-1);
        plan(mk(7'h67, 3'd0, 7'h00), 0, 0, 0);
        chk("len_jalr", pq.size(), 5);
        drive(-1);
        plan(mk(7'h7F, 3'd0, 7'h00), 0, 0, 0);
        chk("len_ill", pq.size(), 3);
        drive(-1);

        plan(32'h002081B3, 0, TMO, 0);
        chk("len_tmo", pq.size(), 9);
        chk("tmo_berr", {31'd0, pq[4].e.berr}, 32'd1);
        drive(-1);
        plan(32'h002081B3, 0, TMO - 1, 0); drive(-1);
        plan(mk(7'h03, 3'd2, 7'h00), 0, 0, TMO); drive(-1);
        plan(mk(7'h23, 3'd2, 7'h00), 0, 0, TMO); drive(-1);

        plan(mk(7'h23, 3'd2, 7'h00), 0, 0, 3);
        drive(4);
        chk("pre_rst_we", {31'd0, o_mem_we}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_req", {31'd0, o_mem_req}, 32'd0);
        chk("mid_rst_we", {31'd0, o_mem_we}, 32'd0);
        chk("mid_rst_state", {28'd0, o_state}, 32'd0);
        release_reset();
        plan(32'h002081B3, 0, 0, 0); drive(-1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
